race_sequencer: RTL and testbench

- Race-control stage directly upstream of the gear/velocity datapath.
- Generates the `reset_status` and `enable_controller_status` strobes that the gear shifter, rpm, velocity and position stages consume.
- Runs the start-light countdown, detects false starts on the raw gas key, measures race time in centiseconds, and detects the finish by comparing the accumulated position against a finish-line constant.

---
 rtl/race_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_race_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// Race-control sequencer: start-light countdown, false-start detection,
// centisecond race timer and finish-line detection for the gear/velocity datapath.
module race_sequencer #(
    parameter int unsigned TICK_DIV    = 650000,
    parameter int unsigned LIGHT_TICKS = 100,
    parameter int unsigned FINISH_POS  = 40200,
    parameter int unsigned TIME_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_key_tick,
    input  logic              gas_key,
    input  logic [31:0]       position,
    output logic              reset_status,
    output logic              enable_controller_status,
    output logic [2:0]        lights,
    output logic              false_start,
    output logic              finished,
    output logic [TIME_W-1:0] race_time,
    output logic [2:0]        seq_state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LW = (LIGHT_TICKS > 1) ? $clog2(LIGHT_TICKS) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0]     LIGHT_MAX = LW'(LIGHT_TICKS - 1);
    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARM         = 3'd1,
        ST_COUNTDOWN   = 3'd2,
        ST_RACE        = 3'd3,
        ST_FINISH      = 3'd4,
        ST_FALSE_START = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [LW-1:0]     light_cnt_q, light_cnt_d;
    logic [1:0]        step_q, step_d;
    logic [2:0]        lights_q, lights_d;
    logic              reset_status_q, reset_status_d;
    logic              enable_q, enable_d;
    logic              false_start_q, false_start_d;
    logic              finished_q, finished_d;
    logic [TIME_W-1:0] race_time_q, race_time_d;

    logic              counting_s;
    logic              tick_s;
    logic              last_step_s;
    logic              finish_hit_s;

    // Light pattern shown for each countdown step.
    function automatic logic [2:0] lights_of(input logic [1:0] step);
        logic [2:0] pat;
        case (step)
            2'd0:    pat = 3'b000;
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            2'd3:    pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    assign counting_s   = (state_q == ST_COUNTDOWN) || (state_q == ST_RACE);
    assign tick_s       = counting_s && (presc_q == PRESC_MAX);
    assign last_step_s  = tick_s && (light_cnt_q == LIGHT_MAX) && (step_q == 2'd3);
    assign finish_hit_s = (position >= 32'(FINISH_POS));

    // Next-state selection; start_key_tick outranks every other event outside ARM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_key_tick) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (start_key_tick) begin
                    state_d = ST_ARM;
                end else if (gas_key) begin
                    state_d = ST_FALSE_START;
                end else if (last_step_s) begin
                    state_d = ST_RACE;
                end else begin
                    state_d = ST_COUNTDOWN;
                end
            end
            ST_RACE: begin
                if (start_key_tick) begin
                    state_d = ST_ARM;
                end else if (finish_hit_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_RACE;
                end
            end
            ST_FINISH, ST_FALSE_START: begin
                if (start_key_tick) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tick prescaler: runs only while counting down or racing, zeroed on arming.
    always_comb begin
        presc_d = presc_q;
        if (state_d == ST_ARM) begin
            presc_d = '0;
        end else if (counting_s) begin
            if (tick_s) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Lights, flags and race timer; all are computed for the state being entered.
    always_comb begin
        light_cnt_d    = light_cnt_q;
        step_d         = step_q;
        lights_d       = lights_q;
        false_start_d  = false_start_q;
        finished_d     = finished_q;
        race_time_d    = race_time_q;
        reset_status_d = (state_d == ST_ARM);
        enable_d       = (state_d == ST_RACE);
        if (state_d == ST_ARM) begin
            light_cnt_d   = '0;
            step_d        = 2'd0;
            lights_d      = 3'b000;
            false_start_d = 1'b0;
            finished_d    = 1'b0;
            race_time_d   = '0;
        end else begin
            case (state_q)
                ST_COUNTDOWN: begin
                    if (state_d == ST_FALSE_START) begin
                        false_start_d = 1'b1;
                        lights_d      = 3'b000;
                    end else if (tick_s) begin
                        if (light_cnt_q == LIGHT_MAX) begin
                            light_cnt_d = '0;
                            step_d      = step_q + 2'd1;
                            lights_d    = lights_of(step_q + 2'd1);
                        end else begin
                            light_cnt_d = light_cnt_q + LW'(1);
                        end
                    end else begin
                        light_cnt_d = light_cnt_q;
                    end
                end
                ST_RACE: begin
                    // Saturate rather than wrap so a long race never reads as a short one.
                    if (tick_s && (race_time_q != TIME_MAX)) begin
                        race_time_d = race_time_q + TIME_W'(1);
                    end else begin
                        race_time_d = race_time_q;
                    end
                    if (state_d == ST_FINISH) begin
                        finished_d = 1'b1;
                    end else begin
                        finished_d = finished_q;
                    end
                end
                default: begin
                    light_cnt_d = light_cnt_q;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            light_cnt_q    <= '0;
            step_q         <= 2'd0;
            lights_q       <= 3'b000;
            reset_status_q <= 1'b0;
            enable_q       <= 1'b0;
            false_start_q  <= 1'b0;
            finished_q     <= 1'b0;
            race_time_q    <= '0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            light_cnt_q    <= light_cnt_d;
            step_q         <= step_d;
            lights_q       <= lights_d;
            reset_status_q <= reset_status_d;
            enable_q       <= enable_d;
            false_start_q  <= false_start_d;
            finished_q     <= finished_d;
            race_time_q    <= race_time_d;
        end
    end

    assign reset_status             = reset_status_q;
    assign enable_controller_status = enable_q;
    assign lights                   = lights_q;
    assign false_start              = false_start_q;
    assign finished                 = finished_q;
    assign race_time                = race_time_q;
    assign seq_state                = state_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: cycle-level reference model compared every cycle,
// plus directed literal checks for reset, countdown, finish, false start and saturation.
module tb_race_sequencer;
    localparam int TD = 4;
    localparam int LT = 2;
    localparam int FP = 100;
    localparam int TW = 4;
    localparam int CD_LEN = 4 * LT * TD;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_key_tick = 1'b0;
    logic          gas_key = 1'b0;
    logic [31:0]   position = 32'd0;
    logic          reset_status;
    logic          enable_controller_status;
    logic [2:0]    lights;
    logic          false_start;
    logic          finished;
    logic [TW-1:0] race_time;
    logic [2:0]    seq_state;

    int n_checks = 0;
    int n_fail = 0;

    race_sequencer #(.TICK_DIV(TD), .LIGHT_TICKS(LT), .FINISH_POS(FP), .TIME_W(TW)) dut (
        .clk(clk), .rst(rst), .start_key_tick(start_key_tick), .gas_key(gas_key),
        .position(position), .reset_status(reset_status),
        .enable_controller_status(enable_controller_status), .lights(lights),
        .false_start(false_start), .finished(finished), .race_time(race_time),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus elapsed cycles in countdown/race.
    int m_st = 0;
    int m_cd = 0;
    int m_rc = 0;
    bit m_fs = 1'b0;
    bit m_fin = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 0; m_cd <= 0; m_rc <= 0; m_fs <= 1'b0; m_fin <= 1'b0;
        end else if (start_key_tick && m_st != 1) begin
            m_st <= 1; m_cd <= 0; m_rc <= 0; m_fs <= 1'b0; m_fin <= 1'b0;
        end else begin
            case (m_st)
                1: begin m_st <= 2; m_cd <= 0; end
                2: begin
                    if (gas_key) begin
                        m_st <= 5; m_fs <= 1'b1;
                    end else if (m_cd + 1 == CD_LEN) begin
                        m_st <= 3; m_cd <= 0; m_rc <= 0;
                    end else begin
                        m_cd <= m_cd + 1;
                    end
                end
                3: begin
                    m_rc <= m_rc + 1;
                    if (position >= FP) begin m_st <= 4; m_fin <= 1'b1; end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [2:0] exp_lights();
        if (m_st != 2) return 3'b000;
        case (m_cd / (TD * LT))
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int exp_time();
        int t;
        t = m_rc / TD;
        if (t > TMAX) t = TMAX;
        return t;
    endfunction

    always @(negedge clk) begin
        n_checks++;
        if (seq_state !== 3'(m_st) || reset_status !== (m_st == 1) ||
            enable_controller_status !== (m_st == 3) || lights !== exp_lights() ||
            false_start !== m_fs || finished !== m_fin || race_time !== TW'(exp_time())) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t got st=%0d rs=%b en=%b li=%b fs=%b fin=%b rt=%0d required st=%0d rs=%b en=%b li=%b fs=%b fin=%b rt=%0d",
                     $time, seq_state, reset_status, enable_controller_status, lights,
                     false_start, finished, race_time, m_st, (m_st == 1), (m_st == 3),
                     exp_lights(), m_fs, m_fin, exp_time());
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(2);
        check("reset_hold_state", int'(seq_state), 0);
        rst = 1'b1;
        cyc(3);
        check("idle_after_release", int'(seq_state), 0);

        // Asynchronous reset in the middle of the countdown.
        start_key_tick = 1'b1; cyc(1); start_key_tick = 1'b0;
        cyc(11);
        check("pre_reset_lights", int'(lights), 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_state", int'(seq_state), 0);
        check("async_reset_lights", int'(lights), 0);
        check("async_reset_flags", int'({reset_status, enable_controller_status, false_start, finished}), 0);
        check("async_reset_time", int'(race_time), 0);
        @(posedge clk); #1; rst = 1'b1;
        cyc(5);
        check("idle_no_start", int'(seq_state), 0);

        // Normal start with a stale over-threshold position during countdown.
        start_key_tick = 1'b1; cyc(1);
        check("arm_pulse", int'(reset_status), 1);
        check("arm_state", int'(seq_state), 1);
        start_key_tick = 1'b0; position = 32'd200; cyc(1);
        check("arm_one_cycle", int'(reset_status), 0);
        check("countdown_state", int'(seq_state), 2);
        cyc(8);  check("lights_c8", int'(lights), 3'b001);
        cyc(8);  check("lights_c16", int'(lights), 3'b011);
        cyc(8);  check("lights_c24", int'(lights), 3'b111);
        cyc(8);  check("lights_c32", int'(lights), 3'b000);
        check("enable_c32", int'(enable_controller_status), 1);
        check("race_state", int'(seq_state), 3);

        position = 32'd99; cyc(40);
        check("race_time_40", int'(race_time), 10);
        position = 32'd100; cyc(1);
        check("finish_flag", int'(finished), 1);
        check("finish_enable", int'(enable_controller_status), 0);
        check("finish_state", int'(seq_state), 4);
        cyc(10);
        check("finish_time_frozen", int'(race_time), 10);

        // False start at countdown cycle 5, then restart.
        start_key_tick = 1'b1; cyc(1);
        check("restart_from_finish", int'(seq_state), 1);
        check("finished_cleared", int'(finished), 0);
        start_key_tick = 1'b0; position = 32'd0; cyc(1);
        cyc(5);
        gas_key = 1'b1; cyc(1); gas_key = 1'b0;
        check("fs_state", int'(seq_state), 5);
        check("fs_flag", int'(false_start), 1);
        check("fs_lights", int'(lights), 0);
        check("fs_enable", int'(enable_controller_status), 0);
        cyc(3);
        start_key_tick = 1'b1; cyc(1);
        check("fs_restart_state", int'(seq_state), 1);
        check("fs_cleared", int'(false_start), 0);
        start_key_tick = 1'b0;

        // Start and finish in the same RACE cycle: start wins.
        cyc(1); cyc(CD_LEN); cyc(9);
        check("race_time_9", int'(race_time), 2);
        start_key_tick = 1'b1; position = 32'd100; gas_key = 1'b1; cyc(1);
        check("simul_state", int'(seq_state), 1);
        check("simul_pulse", int'(reset_status), 1);
        check("simul_time", int'(race_time), 0);
        start_key_tick = 1'b0; position = 32'd50; gas_key = 1'b0;

        // Saturation: 80 ticks into a 4-bit timer.
        cyc(1); cyc(CD_LEN);
        gas_key = 1'b1;
        cyc(320);
        check("sat_time", int'(race_time), 15);
        gas_key = 1'b0;
        cyc(8);
        check("sat_hold", int'(race_time), 15);
        check("sat_state", int'(seq_state), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
